// File: rtl/reaction_meter.sv
// Reaction-time meter: measures ms from light to button in packed BCD, flags false starts and timeouts.
// Optional macro REACTION_BEST_TIME_EN adds a 'best' output that holds the best non-timeout result.
module reaction_meter #(
    parameter int TIMEOUT_MS = 2000
) (
    input  logic        clk1k,
    input  logic        reset,
    input  logic        arm,
    input  logic        light,
    input  logic        btn,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        false_start,
    output logic        timeout,
    output logic        busy
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [15:0] best
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_FOUL    = 3'd4;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Decimal increment with ripple carry; saturates at 9999 so no nibble ever leaves 0..9.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) begin
            r = v;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!carry) begin
                    r[i*4 +: 4] = v[i*4 +: 4];
                end else if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [15:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);

    logic [2:0]  state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        false_start_q, false_start_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;
    logic [15:0] bcd_inc_s;

    assign bcd_inc_s = bcd_inc(bcd_q);

    // Next-state and output decode; arm overrides everything except reset.
    always_comb begin
        state_d       = state_q;
        bcd_d         = bcd_q;
        valid_d       = valid_q;
        false_start_d = false_start_q;
        timeout_d     = timeout_q;
        if (arm) begin
            state_d       = S_WAIT;
            bcd_d         = 16'h0000;
            valid_d       = 1'b0;
            false_start_d = 1'b0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_WAIT: begin
                    if (btn) begin
                        state_d       = S_FOUL;
                        false_start_d = 1'b1;
                    end else if (light) begin
                        state_d = S_MEASURE;
                        bcd_d   = 16'h0000;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_MEASURE: begin
                    if (btn) begin
                        state_d = S_DONE;
                        bcd_d   = bcd_inc_s;
                        valid_d = 1'b1;
                    end else if (bcd_inc_s == TIMEOUT_BCD) begin
                        state_d   = S_DONE;
                        bcd_d     = TIMEOUT_BCD;
                        valid_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        bcd_d = bcd_inc_s;
                    end
                end
                S_DONE: state_d = S_DONE;
                S_FOUL: state_d = S_FOUL;
                default: begin
                    state_d       = S_IDLE;
                    bcd_d         = 16'h0000;
                    valid_d       = 1'b0;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == S_WAIT) || (state_d == S_MEASURE);
    end

    // State and registered outputs.
    always_ff @(posedge clk1k) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bcd_q         <= 16'h0000;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            valid_q       <= valid_d;
            false_start_q <= false_start_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign bcd         = bcd_q;
    assign valid       = valid_q;
    assign false_start = false_start_q;
    assign timeout     = timeout_q;
    assign busy        = busy_q;

`ifdef REACTION_BEST_TIME_EN
    logic [15:0] best_q, best_d;

    // Packed BCD orders the same as its decimal value, so a plain compare is digit-wise.
    always_comb begin
        if ((state_q == S_MEASURE) && (state_d == S_DONE) && !timeout_d && (bcd_d < best_q)) begin
            best_d = bcd_d;
        end else begin
            best_d = best_q;
        end
    end

    // Best-time register.
    always_ff @(posedge clk1k) begin
        if (reset) begin
            best_q <= 16'h9999;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
`endif

endmodule

// File: tb/tb_reaction_meter.sv
// Scoreboard bench for reaction_meter: round results queued by stimulus, checked by a monitor.
module tb_reaction_meter;

    logic        clk = 1'b0;
    logic        reset, arm, light, btn;
    logic [15:0] bcd;
    logic        valid, false_start, timeout, busy;
`ifdef REACTION_BEST_TIME_EN
    logic [15:0] best;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];
    logic        prev_ev = 1'b0;

    always #5 clk = ~clk;

    reaction_meter #(.TIMEOUT_MS(2000)) dut (
        .clk1k(clk), .reset(reset), .arm(arm), .light(light), .btn(btn),
        .bcd(bcd), .valid(valid), .false_start(false_start), .timeout(timeout), .busy(busy)
`ifdef REACTION_BEST_TIME_EN
        , .best(best)
`endif
    );

    function automatic logic [19:0] act();
        return {bcd, valid, false_start, timeout, busy};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got bcd/v/fs/to/busy=%h expected %h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: each new result (valid or false_start rising) is checked against the queue head.
    always @(negedge clk) begin
        logic ev;
        ev = valid | false_start;
        if (ev && !prev_ev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", act());
            end else begin
                chk("scoreboard", act(), exp_q.pop_front());
            end
        end
        prev_ev <= ev;
    end

    // Arm, light, then btn sampled n cycles after the light edge.
    task automatic measure_round(input int n, input logic [15:0] want);
        arm = 1'b1; cyc(1); arm = 1'b0;
        light = 1'b1; cyc(1); light = 1'b0;
        cyc(n - 1);
        btn = 1'b1;
        exp_q.push_back({want, 1'b1, 1'b0, 1'b0, 1'b0});
        cyc(1);
        btn = 1'b0;
        cyc(2);
    endtask

    task automatic timeout_round();
        arm = 1'b1; cyc(1); arm = 1'b0;
        light = 1'b1; cyc(1);
        exp_q.push_back({16'h2000, 1'b1, 1'b0, 1'b1, 1'b0});
        cyc(2000);
        light = 1'b0;
        cyc(2);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; light = 1'b0; btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("reset_state", act(), {16'h0000, 4'b0000});
        light = 1'b1; btn = 1'b1; cyc(3);
        chk("idle_hold", act(), {16'h0000, 4'b0000});
        light = 1'b0; btn = 1'b0;

        // 237 ms round with light dropping during MEASURE
        arm = 1'b1; cyc(1); arm = 1'b0;
        chk("wait_entry", act(), {16'h0000, 4'b0001});
        cyc(4); light = 1'b1; cyc(1); light = 1'b0;
        chk("measure_entry", act(), {16'h0000, 4'b0001});
        cyc(236);
        chk("measure_236", act(), {16'h0236, 4'b0001});
        btn = 1'b1;
        exp_q.push_back({16'h0237, 4'b1000});
        cyc(1); btn = 1'b0; cyc(3);
        chk("done_hold", act(), {16'h0237, 4'b1000});

        // False start, FOUL held, then arm+btn together goes to WAIT
        arm = 1'b1; cyc(1); arm = 1'b0;
        chk("rearm_clear", act(), {16'h0000, 4'b0001});
        cyc(2); btn = 1'b1;
        exp_q.push_back({16'h0000, 4'b0100});
        cyc(1); btn = 1'b0; light = 1'b1; cyc(4); light = 1'b0;
        chk("foul_hold", act(), {16'h0000, 4'b0100});
        arm = 1'b1; btn = 1'b1; cyc(1); arm = 1'b0;
        chk("arm_beats_btn", act(), {16'h0000, 4'b0001});
        exp_q.push_back({16'h0000, 4'b0100});
        cyc(1); btn = 1'b0; cyc(1);

        // Timeout with BCD carry checks
        arm = 1'b1; cyc(1); arm = 1'b0;
        light = 1'b1; cyc(1);
        cyc(99);
        chk("bcd_0099", act(), {16'h0099, 4'b0001});
        cyc(1);
        chk("bcd_0100", act(), {16'h0100, 4'b0001});
        cyc(1899);
        chk("bcd_1999", act(), {16'h1999, 4'b0001});
        exp_q.push_back({16'h2000, 4'b1010});
        cyc(1); light = 1'b0; cyc(3);
        chk("timeout_hold", act(), {16'h2000, 4'b1010});

        // Re-arm mid-MEASURE, then light+btn together in WAIT
        arm = 1'b1; cyc(1); arm = 1'b0;
        light = 1'b1; cyc(1); light = 1'b0;
        cyc(50);
        chk("bcd_0050", act(), {16'h0050, 4'b0001});
        arm = 1'b1; cyc(1); arm = 1'b0;
        chk("rearm_mid_measure", act(), {16'h0000, 4'b0001});
        light = 1'b1; btn = 1'b1;
        exp_q.push_back({16'h0000, 4'b0100});
        cyc(1); light = 1'b0; btn = 1'b0; cyc(1);

        // Reset aborts MEASURE; reset beats arm
        arm = 1'b1; cyc(1); arm = 1'b0;
        light = 1'b1; cyc(1); light = 1'b0;
        cyc(10);
        chk("bcd_0010", act(), {16'h0010, 4'b0001});
        reset = 1'b1; cyc(1);
        chk("reset_abort", act(), {16'h0000, 4'b0000});
        arm = 1'b1; cyc(1);
        chk("reset_beats_arm", act(), {16'h0000, 4'b0000});
        reset = 1'b0; arm = 1'b0; cyc(1);

        // Best-time rounds
`ifdef REACTION_BEST_TIME_EN
        chk("best_reset", {best, 4'b0000}, {16'h9999, 4'b0000});
`endif
        measure_round(300, 16'h0300);
`ifdef REACTION_BEST_TIME_EN
        chk("best_300", {best, 4'b0000}, {16'h0300, 4'b0000});
`endif
        measure_round(250, 16'h0250);
        measure_round(400, 16'h0400);
        timeout_round();
`ifdef REACTION_BEST_TIME_EN
        chk("best_250", {best, 4'b0000}, {16'h0250, 4'b0000});
        reset = 1'b1; cyc(1); reset = 1'b0;
        chk("best_after_reset", {best, 4'b0000}, {16'h9999, 4'b0000});
`endif

        cyc(2);
        chk("scoreboard_empty", 20'(exp_q.size()), 20'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_meter.md
REACTION_METER -- requirements
Module: reaction_meter

Interface
REQ-001 Parameter TIMEOUT_MS, default 2000, is the maximum measurable reaction in ms (legal range 1..9999).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk1k  in  1  1 kHz system clock; one cycle = 1 ms.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 arm  in  1  round start pulse, the same signal that loads the down-counter delay.
REQ-006 light  in  1  stimulus-on level, driven by the down-counter expiry output.
REQ-007 btn  in  1  player button level, already debounced and synchronous to clk1k.
REQ-008 bcd  out  16  measured time, four packed BCD digits, ms; [15:12] = thousands.
REQ-009 valid  out  1  a measurement (normal or timeout) is complete.
REQ-010 false_start  out  1  the button was pressed before the light.
REQ-011 timeout  out  1  no press occurred within TIMEOUT_MS.
REQ-012 busy  out  1  the round is in progress (WAIT or MEASURE).

Function
REQ-013 The FSM states SHALL be IDLE, WAIT, MEASURE, DONE and FOUL, and all outputs SHALL be registered.
REQ-014 arm=1 in any state SHALL go to WAIT, set bcd=0x0000 and clear valid, false_start and timeout; arm has priority over btn and light.
REQ-015 IDLE SHALL stay in IDLE until arm.
REQ-016 In WAIT, btn=1 SHALL go to FOUL and set false_start=1; this includes btn held from before arm, and btn and light high in the same cycle.
REQ-017 In WAIT, light=1 with btn=0 SHALL go to MEASURE with bcd=0x0000.
REQ-018 In MEASURE, btn=1 SHALL increment bcd by one, go to DONE and set valid=1, so the result equals the cycle count from the light-sampled edge to the btn-sampled edge.
REQ-019 In MEASURE, with btn=0 and bcd+1 equal to TIMEOUT_MS, the block SHALL load bcd with TIMEOUT_MS in BCD, go to DONE and set valid=1 and timeout=1.
REQ-020 In MEASURE, with btn=0 otherwise, bcd SHALL increment by one.
REQ-021 btn SHALL take priority over timeout in the same cycle.
REQ-022 A light deassertion during MEASURE SHALL be ignored.
REQ-023 BCD increment rules: each digit runs 0..9; 9 wraps to 0 with a carry into the next digit; bcd never exceeds 0x9999 and never holds a non-BCD nibble.
REQ-024 DONE and FOUL SHALL hold all outputs until arm or reset.
REQ-025 busy SHALL be 1 exactly when the state is WAIT or MEASURE.
REQ-026 btn, light and arm SHALL be sampled only on rising clk1k edges, and the block SHALL contain no combinational input-to-output path.

Reset
REQ-027 On reset the block SHALL enter IDLE with bcd=0x0000 and valid, false_start, timeout and busy all 0.
REQ-028 Reset SHALL take priority over arm and SHALL abort any round in progress within one cycle.

Configuration
REQ-029 Macro REACTION_BEST_TIME_EN, when defined, SHALL add the port best (out, 16, best valid non-timeout result in BCD).
REQ-030 With REACTION_BEST_TIME_EN defined, best SHALL reset to 0x9999.
REQ-031 With REACTION_BEST_TIME_EN defined, best SHALL be updated on the DONE-entry edge when timeout=0 and the new result is less than best (digit-wise BCD compare).
REQ-032 With REACTION_BEST_TIME_EN defined, best SHALL be unaffected by arm, false starts and timeouts.
REQ-033 When REACTION_BEST_TIME_EN is undefined, the best port and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, arm, light high 5 cycles later, btn high 237 cycles after light sampled -> bcd=0x0237, valid=1, timeout=0, busy=0.
REQ-035 Arm, btn high 3 cycles later with light low -> false_start=1, valid=0, bcd=0x0000, FOUL held until next arm.
REQ-036 TIMEOUT_MS=2000, light high, btn never pressed -> after 2000 cycles bcd=0x2000, timeout=1, valid=1; bcd shows 0x0099 then 0x0100 on consecutive cycles.
REQ-037 Arm again at bcd=0x0050 in MEASURE -> next cycle WAIT, bcd=0x0000, busy=1, flags cleared; arm and btn in the same cycle -> WAIT, not FOUL.
REQ-038 Light and btn rising in the same WAIT cycle -> FOUL; reset asserted mid-MEASURE -> IDLE, all outputs 0 on the next edge.
REQ-039 With REACTION_BEST_TIME_EN, rounds of 300, 250, 400 ms plus one timeout -> best=0x0250; reset -> best=0x9999.
